// File: rtl/slot_spin_sequencer.sv
// -----------------------------------------------------------------------------
// slot_spin_sequencer
//
// Game-flow controller between the SPI command decoder and the reel/credit
// display drivers. A spin request starts all three reels together; once they
// have spun long enough, they stop in order (reel 1, 2, 3) on their latched
// target symbols. After the last reel stops, the win presentation runs if a
// win was reported. Credit-total updates are held back while the reels move.
//
// Event interface: start_spin, is_win and is_total are single-cycle valid
// strobes with no ready. Their data (reelN_idx, win_credits, total_credits) is
// sampled only in the strobe cycle. A start_spin that cannot be accepted
// because a game is in progress is not queued. It is reported by a
// one-cycle spin_dropped pulse.
//
// Ports
//   clk, reset            system clock, asynchronous active-high reset
//   start_spin            spin request; reel1_idx..reel3_idx sampled with it
//   is_win / win_credits  win event and amount
//   is_total / total_credits  credit-total event and value
//   reel1_pos..reel3_pos  currently displayed symbol of each reel
//   reel_spinning         bit k set while reel k+1 is moving
//   busy                  a game is in progress (state != IDLE)
//   spin_done             one-cycle pulse when the last reel stops
//   spin_dropped          one-cycle pulse when start_spin is ignored
//   win_flash             high during the win presentation
//   win_amount            latched win value
//   display_credits       credits shown to the user
//   debug_state           current FSM state encoding
// All outputs are registered.
// -----------------------------------------------------------------------------
module slot_spin_sequencer #(
  parameter int NUM_SYMBOLS    = 10,
  parameter int STEP_CYCLES    = 2_500_000,
  parameter int MIN_SPIN_STEPS = 12,
  parameter int STAGGER_STEPS  = 4,
  parameter int RESULT_WAIT    = 25_000_000,
  parameter int FLASH_CYCLES   = 100_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start_spin,
  input  logic [3:0]  reel1_idx,
  input  logic [3:0]  reel2_idx,
  input  logic [3:0]  reel3_idx,
  input  logic        is_win,
  input  logic [11:0] win_credits,
  input  logic        is_total,
  input  logic [11:0] total_credits,
  output logic [3:0]  reel1_pos,
  output logic [3:0]  reel2_pos,
  output logic [3:0]  reel3_pos,
  output logic [2:0]  reel_spinning,
  output logic        busy,
  output logic        spin_done,
  output logic        spin_dropped,
  output logic        win_flash,
  output logic [11:0] win_amount,
  output logic [11:0] display_credits,
  output logic [2:0]  debug_state
);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SPIN     = 3'd1,
    ST_RESULT   = 3'd2,
    ST_WIN_SHOW = 3'd3
  } state_t;

  localparam logic [3:0]  LAST_SYM   = 4'(NUM_SYMBOLS - 1);
  localparam logic [4:0]  NUM_SYM_W  = 5'(NUM_SYMBOLS);
  localparam logic [31:0] STEP_LAST  = 32'(STEP_CYCLES - 1);
  localparam logic [31:0] WAIT_LAST  = 32'(RESULT_WAIT - 1);
  localparam logic [31:0] FLASH_LAST = 32'(FLASH_CYCLES - 1);

  // Tick count at which each reel first becomes allowed to stop.
  localparam logic [15:0] ELIG0 = 16'(MIN_SPIN_STEPS);
  localparam logic [15:0] ELIG1 = 16'(MIN_SPIN_STEPS + STAGGER_STEPS);
  localparam logic [15:0] ELIG2 = 16'(MIN_SPIN_STEPS + 2 * STAGGER_STEPS);

  state_t            state_q, state_d;
  logic [31:0]       tmr_q;         // tick timer in SPIN, wait/flash timer later
  logic [15:0]       steps_q;       // ticks completed in the current spin
  logic [2:0][3:0]   pos_q;
  logic [2:0][3:0]   tgt_q;
  logic              pending_win_q;
  logic              pending_total_q;
  logic [11:0]       pending_total_val_q;

  logic              tick;
  logic [2:0]        eligible;
  logic [2:0]        stop_now;
  logic [2:0]        advance;
  logic [2:0]        spin_next;

  // Out-of-range targets are replaced by symbol 0 so a reel always has a
  // reachable stop position.
  function automatic logic [3:0] clamp_target(input logic [3:0] idx);
    return ({1'b0, idx} < NUM_SYM_W) ? idx : 4'd0;
  endfunction

  assign reel1_pos   = pos_q[0];
  assign reel2_pos   = pos_q[1];
  assign reel3_pos   = pos_q[2];
  assign debug_state = state_q;

  // ---------------------------------------------------------------------------
  // Reel stepping decisions for the current cycle
  // ---------------------------------------------------------------------------
  always_comb begin
    tick      = (state_q == ST_SPIN) && (tmr_q == STEP_LAST);
    eligible  = 3'b000;
    stop_now  = 3'b000;
    advance   = 3'b000;
    spin_next = reel_spinning;

    // A reel may stop only after its predecessor has stopped, which keeps
    // the stop order fixed even if a target is reached early.
    eligible[0] = (steps_q >= ELIG0);
    eligible[1] = (steps_q >= ELIG1) && !reel_spinning[0];
    eligible[2] = (steps_q >= ELIG2) && !reel_spinning[1];

    for (int k = 0; k < 3; k++) begin
      stop_now[k] = tick && reel_spinning[k] && eligible[k] && (pos_q[k] == tgt_q[k]);
      advance[k]  = tick && reel_spinning[k] && !stop_now[k];
    end
    spin_next = reel_spinning & ~stop_now;
  end

  // ---------------------------------------------------------------------------
  // FSM: state register and next-state logic
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start_spin) state_d = ST_SPIN;
      end
      ST_SPIN: begin
        if (tick && (spin_next == 3'b000)) state_d = ST_RESULT;
      end
      ST_RESULT: begin
        // A win (pending or arriving now) beats the timeout.
        if (pending_win_q || is_win) state_d = ST_WIN_SHOW;
        else if (tmr_q == WAIT_LAST) state_d = ST_IDLE;
      end
      ST_WIN_SHOW: begin
        if (tmr_q == FLASH_LAST) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath and registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tmr_q               <= '0;
      steps_q             <= '0;
      pos_q               <= '0;
      tgt_q               <= '0;
      reel_spinning       <= 3'b000;
      busy                <= 1'b0;
      spin_done           <= 1'b0;
      spin_dropped        <= 1'b0;
      win_flash           <= 1'b0;
      win_amount          <= '0;
      display_credits     <= '0;
      pending_win_q       <= 1'b0;
      pending_total_q     <= 1'b0;
      pending_total_val_q <= '0;
    end else begin
      spin_done    <= 1'b0;
      spin_dropped <= 1'b0;
      busy         <= (state_d != ST_IDLE);
      win_flash    <= (state_d == ST_WIN_SHOW);

      // One shared timer: restarted on every state change and on each tick.
      if ((state_d != state_q) || tick) begin
        tmr_q <= '0;
      end else if (state_q != ST_IDLE) begin
        tmr_q <= tmr_q + 32'd1;
      end

      // Spin requests. Positions deliberately carry over from the last game.
      if (start_spin) begin
        if (state_q == ST_IDLE) begin
          tgt_q         <= {clamp_target(reel3_idx), clamp_target(reel2_idx),
                            clamp_target(reel1_idx)};
          steps_q       <= '0;
          reel_spinning <= 3'b111;
        end else begin
          spin_dropped <= 1'b1;
        end
      end

      if (tick) begin
        if (steps_q != 16'hFFFF) steps_q <= steps_q + 16'd1;
        reel_spinning <= spin_next;
        if (reel_spinning[2] && !spin_next[2]) spin_done <= 1'b1;
        for (int k = 0; k < 3; k++) begin
          if (advance[k]) pos_q[k] <= (pos_q[k] == LAST_SYM) ? 4'd0 : pos_q[k] + 4'd1;
        end
      end else if (state_d == ST_IDLE) begin
        reel_spinning <= 3'b000;
      end

      // Win events: latest value wins; ignored once the presentation runs.
      if (is_win && (state_q != ST_WIN_SHOW)) begin
        win_amount <= win_credits;
        if ((state_q == ST_IDLE) || (state_q == ST_SPIN)) pending_win_q <= 1'b1;
      end
      if ((state_d == ST_WIN_SHOW) && (state_q != ST_WIN_SHOW)) pending_win_q <= 1'b0;

      // Credit totals: frozen while reels move, released on SPIN exit.
      if (state_q == ST_SPIN) begin
        if (state_d != ST_SPIN) begin
          if (is_total) display_credits <= total_credits;
          else if (pending_total_q) display_credits <= pending_total_val_q;
          pending_total_q <= 1'b0;
        end else if (is_total) begin
          pending_total_q     <= 1'b1;
          pending_total_val_q <= total_credits;
        end
      end else if (is_total) begin
        display_credits <= total_credits;
      end
    end
  end

endmodule

// File: tb/tb_slot_spin_sequencer.sv
`timescale 1ns/1ps
module tb_slot_spin_sequencer;

  localparam int NUM   = 10;
  localparam int STEP  = 2;
  localparam int MINS  = 12;
  localparam int STAG  = 4;
  localparam int WAITC = 20;
  localparam int FLASH = 16;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start_spin = 1'b0;
  logic [3:0]  reel1_idx = '0, reel2_idx = '0, reel3_idx = '0;
  logic        is_win = 1'b0;
  logic [11:0] win_credits = '0;
  logic        is_total = 1'b0;
  logic [11:0] total_credits = '0;
  logic [3:0]  reel1_pos, reel2_pos, reel3_pos;
  logic [2:0]  reel_spinning;
  logic        busy, spin_done, spin_dropped, win_flash;
  logic [11:0] win_amount, display_credits;
  logic [2:0]  debug_state;

  always #5 clk = ~clk;

  slot_spin_sequencer #(
    .NUM_SYMBOLS(NUM), .STEP_CYCLES(STEP), .MIN_SPIN_STEPS(MINS),
    .STAGGER_STEPS(STAG), .RESULT_WAIT(WAITC), .FLASH_CYCLES(FLASH)
  ) dut (
    .clk(clk), .reset(reset), .start_spin(start_spin),
    .reel1_idx(reel1_idx), .reel2_idx(reel2_idx), .reel3_idx(reel3_idx),
    .is_win(is_win), .win_credits(win_credits),
    .is_total(is_total), .total_credits(total_credits),
    .reel1_pos(reel1_pos), .reel2_pos(reel2_pos), .reel3_pos(reel3_pos),
    .reel_spinning(reel_spinning), .busy(busy), .spin_done(spin_done),
    .spin_dropped(spin_dropped), .win_flash(win_flash),
    .win_amount(win_amount), .display_credits(display_credits),
    .debug_state(debug_state)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // ---------------------------------------------------------------------------
  // Scoreboard: expected final positions {reel3, reel2, reel1}, pushed when a
  // spin is requested and popped when spin_done pulses.
  // ---------------------------------------------------------------------------
  logic [11:0] exp_q[$];
  logic [11:0] sb_exp;
  logic [11:0] sb_got;

  always @(negedge clk) begin
    if (spin_done === 1'b1) begin
      n_checks++;
      sb_got = {reel3_pos, reel2_pos, reel1_pos};
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_stop: spin_done with nothing expected, positions %h", sb_got);
      end else begin
        sb_exp = exp_q.pop_front();
        if (sb_got !== sb_exp) begin
          n_fail++;
          $display("FAIL sb_stop: positions got %h expected %h", sb_got, sb_exp);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Driver tasks (called at a negedge, return at a negedge)
  // ---------------------------------------------------------------------------
  function automatic logic [3:0] exp_target(input logic [3:0] t);
    return (int'(t) >= NUM) ? 4'd0 : t;
  endfunction

  task automatic drive_spin(input logic [3:0] t1, input logic [3:0] t2, input logic [3:0] t3);
    reel1_idx  = t1;
    reel2_idx  = t2;
    reel3_idx  = t3;
    start_spin = 1'b1;
    exp_q.push_back({exp_target(t3), exp_target(t2), exp_target(t1)});
    @(negedge clk);
    start_spin = 1'b0;
  endtask

  task automatic wait_spin_done(input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit && !ok; i++) begin
      @(negedge clk);
      if (spin_done === 1'b1) ok = 1'b1;
    end
  endtask

  task automatic wait_idle(input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit && !ok; i++) begin
      @(negedge clk);
      if (busy === 1'b0) ok = 1'b1;
    end
  endtask

  // ---------------------------------------------------------------------------
  // Tests
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++; if ({reel3_pos, reel2_pos, reel1_pos} !== 12'h000) begin n_fail++; $display("FAIL reset_pos: got %h expected 000", {reel3_pos, reel2_pos, reel1_pos}); end
    n_checks++; if (reel_spinning !== 3'b000) begin n_fail++; $display("FAIL reset_spinning: got %b expected 000", reel_spinning); end
    n_checks++; if ({busy, spin_done, spin_dropped, win_flash} !== 4'b0000) begin n_fail++; $display("FAIL reset_flags: got %b expected 0000", {busy, spin_done, spin_dropped, win_flash}); end
    n_checks++; if (win_amount !== 12'd0) begin n_fail++; $display("FAIL reset_win_amount: got %0d expected 0", win_amount); end
    n_checks++; if (display_credits !== 12'd0) begin n_fail++; $display("FAIL reset_display: got %0d expected 0", display_credits); end
    reset = 1'b0;
    @(negedge clk);
    n_checks++; if (debug_state !== 3'd0 || busy !== 1'b0) begin n_fail++; $display("FAIL reset_idle: state %0d busy %b expected 0 0", debug_state, busy); end
  endtask

  task automatic test_credit_idle();
    is_total = 1'b1;
    total_credits = 12'd25;
    @(negedge clk);
    is_total = 1'b0;
    n_checks++; if (display_credits !== 12'd25) begin n_fail++; $display("FAIL credit_idle: got %0d expected 25", display_credits); end
  endtask

  // Targets 3,7,0 from positions 0: reel 1 stops on tick 14, reel 2 on tick 18,
  // reel 3 on tick 21 (ticks every 2 cycles). Credits 40/55 arrive mid-spin,
  // a spin request is dropped, and no win leads to the RESULT timeout.
  task automatic test_ordered_stop();
    int n;
    logic [2:0] exp_spin;
    logic [3:0] e0, e1, e2;
    drive_spin(4'd3, 4'd7, 4'd0);
    n_checks++; if (reel_spinning !== 3'b111 || busy !== 1'b1) begin n_fail++; $display("FAIL spin_start: spinning %b busy %b expected 111 1", reel_spinning, busy); end
    for (int c = 1; c <= 70; c++) begin
      is_total      = (c == 6) || (c == 11);
      total_credits = (c == 6) ? 12'd40 : 12'd55;
      start_spin    = (c == 21);
      if (c == 21) begin reel1_idx = 4'd9; reel2_idx = 4'd9; reel3_idx = 4'd9; end
      @(negedge clk);
      n = c / 2;
      exp_spin = {c < 42, c < 36, c < 28};
      e0 = (n <= 13) ? 4'(n % 10) : 4'd3;
      e1 = (n <= 17) ? 4'(n % 10) : 4'd7;
      e2 = (n <= 20) ? 4'(n % 10) : 4'd0;
      n_checks++; if (reel_spinning !== exp_spin) begin n_fail++; $display("FAIL order_spinning c=%0d: got %b expected %b", c, reel_spinning, exp_spin); end
      n_checks++; if ({reel3_pos, reel2_pos, reel1_pos} !== {e2, e1, e0}) begin n_fail++; $display("FAIL order_pos c=%0d: got %h expected %h", c, {reel3_pos, reel2_pos, reel1_pos}, {e2, e1, e0}); end
      n_checks++; if (spin_done !== (c == 42)) begin n_fail++; $display("FAIL order_done c=%0d: got %b expected %b", c, spin_done, (c == 42)); end
      n_checks++; if (display_credits !== ((c >= 42) ? 12'd55 : 12'd25)) begin n_fail++; $display("FAIL credit_defer c=%0d: got %0d expected %0d", c, display_credits, (c >= 42) ? 55 : 25); end
      n_checks++; if (spin_dropped !== (c == 21)) begin n_fail++; $display("FAIL drop_pulse c=%0d: got %b expected %b", c, spin_dropped, (c == 21)); end
      n_checks++; if (busy !== (c < 42 + WAITC)) begin n_fail++; $display("FAIL nowin_busy c=%0d: got %b expected %b", c, busy, (c < 42 + WAITC)); end
      n_checks++; if (win_flash !== 1'b0) begin n_fail++; $display("FAIL nowin_flash c=%0d: got %b expected 0", c, win_flash); end
    end
    is_total   = 1'b0;
    start_spin = 1'b0;
  endtask

  task automatic test_drop_and_clamp();
    bit ok;
    drive_spin(4'd12, 4'd5, 4'd12);
    start_spin = 1'b1;
    reel1_idx = 4'd4; reel2_idx = 4'd4; reel3_idx = 4'd4;
    @(negedge clk);
    start_spin = 1'b0;
    n_checks++; if (spin_dropped !== 1'b1) begin n_fail++; $display("FAIL drop_busy: got %b expected 1", spin_dropped); end
    @(negedge clk);
    n_checks++; if (spin_dropped !== 1'b0) begin n_fail++; $display("FAIL drop_once: got %b expected 0", spin_dropped); end
    wait_spin_done(200, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL clamp_done: spin_done got none expected within 200 cycles"); end
    wait_idle(100, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL clamp_idle: busy got 1 expected 0 within 100 cycles"); end
  endtask

  task automatic test_win_path();
    bit ok;
    int flash_n;
    drive_spin(4'd1, 4'd2, 4'd3);
    repeat (3) @(negedge clk);
    is_win = 1'b1;
    win_credits = 12'h064;
    @(negedge clk);
    is_win = 1'b0;
    wait_spin_done(200, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL win_done: spin_done got none expected within 200 cycles"); end
    @(negedge clk);
    n_checks++; if (win_flash !== 1'b1) begin n_fail++; $display("FAIL win_enter: win_flash got %b expected 1", win_flash); end
    flash_n = 0;
    while (win_flash === 1'b1 && flash_n < 100) begin
      n_checks++; if (win_amount !== 12'd100) begin n_fail++; $display("FAIL win_amount: got %0d expected 100", win_amount); end
      flash_n++;
      @(negedge clk);
    end
    n_checks++; if (flash_n != FLASH) begin n_fail++; $display("FAIL win_length: got %0d expected %0d", flash_n, FLASH); end
    n_checks++; if (busy !== 1'b0 || debug_state !== 3'd0) begin n_fail++; $display("FAIL win_exit: busy %b state %0d expected 0 0", busy, debug_state); end
  endtask

  // is_win on the very cycle the RESULT wait would expire: the win takes it.
  task automatic test_result_win();
    bit ok;
    drive_spin(4'd2, 4'd2, 4'd2);
    wait_spin_done(200, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL rwin_done: spin_done got none expected within 200 cycles"); end
    repeat (WAITC - 1) @(negedge clk);
    n_checks++; if (busy !== 1'b1 || win_flash !== 1'b0) begin n_fail++; $display("FAIL rwin_wait: busy %b flash %b expected 1 0", busy, win_flash); end
    is_win = 1'b1;
    win_credits = 12'h0AB;
    @(negedge clk);
    is_win = 1'b0;
    n_checks++; if (win_flash !== 1'b1) begin n_fail++; $display("FAIL rwin_priority: win_flash got %b expected 1", win_flash); end
    n_checks++; if (win_amount !== 12'h0AB) begin n_fail++; $display("FAIL rwin_amount: got %h expected 0ab", win_amount); end
    wait_idle(100, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL rwin_idle: busy got 1 expected 0 within 100 cycles"); end
  endtask

  // start_spin and is_total together in IDLE, then a second spin right after.
  task automatic test_back_to_back();
    bit ok;
    is_total = 1'b1;
    total_credits = 12'd77;
    drive_spin(4'd4, 4'd8, 4'd1);
    is_total = 1'b0;
    n_checks++; if (display_credits !== 12'd77) begin n_fail++; $display("FAIL b2b_credit: got %0d expected 77", display_credits); end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL b2b_busy: got %b expected 1", busy); end
    wait_spin_done(200, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL b2b_done1: spin_done got none expected within 200 cycles"); end
    wait_idle(100, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL b2b_idle1: busy got 1 expected 0 within 100 cycles"); end
    drive_spin(4'd9, 4'd0, 4'd5);
    wait_spin_done(200, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL b2b_done2: spin_done got none expected within 200 cycles"); end
    wait_idle(100, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL b2b_idle2: busy got 1 expected 0 within 100 cycles"); end
  endtask

  task automatic test_mid_spin_reset();
    bit ok;
    int done_c;
    drive_spin(4'd5, 4'd5, 4'd5);
    repeat (16) @(negedge clk);
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL mid_busy: got %b expected 1", busy); end
    #1 reset = 1'b1;
    #1;
    n_checks++; if ({reel3_pos, reel2_pos, reel1_pos} !== 12'h000) begin n_fail++; $display("FAIL mid_reset_pos: got %h expected 000", {reel3_pos, reel2_pos, reel1_pos}); end
    n_checks++; if ({reel_spinning, busy, win_flash, spin_done} !== 6'd0) begin n_fail++; $display("FAIL mid_reset_flags: got %b expected 000000", {reel_spinning, busy, win_flash, spin_done}); end
    n_checks++; if (debug_state !== 3'd0 || display_credits !== 12'd0 || win_amount !== 12'd0) begin n_fail++; $display("FAIL mid_reset_regs: state %0d credits %0d win %0d expected 0 0 0", debug_state, display_credits, win_amount); end
    exp_q.delete();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    drive_spin(4'd3, 4'd7, 4'd0);
    done_c = 0;
    for (int c = 1; c <= 60 && done_c == 0; c++) begin
      @(negedge clk);
      if (spin_done === 1'b1) done_c = c;
    end
    n_checks++; if (done_c != 42) begin n_fail++; $display("FAIL mid_fresh_done: cycle got %0d expected 42", done_c); end
    wait_idle(100, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL mid_fresh_idle: busy got 1 expected 0 within 100 cycles"); end
  endtask

  // ---------------------------------------------------------------------------
  // Sequence and report
  // ---------------------------------------------------------------------------
  initial begin
    test_reset();
    test_credit_idle();
    test_ordered_stop();
    test_drop_and_clamp();
    test_win_path();
    test_result_win();
    test_back_to_back();
    test_mid_spin_reset();
    repeat (2) @(negedge clk);
    n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL sb_leftover: queued stops got %0d expected 0", exp_q.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
